// File: rtl/cbus_sram_responder.sv
// Cache-bus SRAM responder: captures one burst request at a time, waits a
// fixed latency, then streams len+1 read or write beats over a word array
// whose index wraps at the top of memory.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    // Burst length encodings: beats minus one
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] base_q;
    logic          wr_q;
    logic [3:0]    len_q;
    logic [3:0]    beat_cnt;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] word_idx;
    logic          capture;
    logic          beat;
    logic [31:0]   mem [MEM_WORDS];
    logic          unused_bits;

    // Size and the byte/high address bits never influence behaviour
    assign unused_bits = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

    // Word addressed by the current beat, wrapping naturally at AW bits
    assign word_idx = base_q + AW'(beat_cnt);

    // Next-state decode and response outputs; a dropped valid aborts at once
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        beat       = 1'b0;
        cresp      = '0;
        case (state)
            IDLE: begin
                if (creq.valid) begin
                    capture    = 1'b1;
                    state_next = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    state_next = IDLE;
                end else if (lat_cnt == LAT_LAST) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    state_next = IDLE;
                end else begin
                    beat        = 1'b1;
                    cresp.ready = 1'b1;
                    cresp.last  = (beat_cnt == len_q);
                    cresp.data  = wr_q ? 32'd0 : mem[word_idx];
                    if (beat_cnt == len_q) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture plus latency and beat counters, restarted on each capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q   <= '0;
            wr_q     <= 1'b0;
            len_q    <= 4'd0;
            beat_cnt <= 4'd0;
            lat_cnt  <= 4'd0;
        end else if (capture) begin
            base_q   <= creq.addr[AW+1:2];
            wr_q     <= creq.is_write;
            len_q    <= creq.len;
            beat_cnt <= 4'd0;
            lat_cnt  <= 4'd0;
        end else begin
            if (state == WAIT) begin
                lat_cnt <= lat_cnt + 4'd1;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    // Byte-lane write into the array on each accepted write beat
    always_ff @(posedge clk) begin
        if (beat && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) begin
                    mem[word_idx][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: one instance with LATENCY=2 and one with
// LATENCY=0, driven from a shared request and checked against a word-array
// model that predicts beat timing from the latency and burst length.

module tb_cbus_sram_responder;
    import cbus_pkg::*;

    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sel;
    cbus_req_t  req_drv;
    cbus_req_t  creq2;
    cbus_req_t  creq0;
    cbus_resp_t cresp2;
    cbus_resp_t cresp0;
    cbus_resp_t resp_sel;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem_model [2][N];
    bit          known     [2][N];
    logic [31:0] wdata  [16];
    logic [3:0]  wstrb  [16];
    logic [31:0] rd_obs [16];
    logic [3:0]  len_tab [5];

    assign creq2    = sel ? '0 : req_drv;
    assign creq0    = sel ? req_drv : '0;
    assign resp_sel = sel ? cresp0 : cresp2;

    always #5 clk = ~clk;

    cbus_sram_responder #(.MEM_WORDS(N), .LATENCY(2)) dut2 (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq2),
        .cresp  (cresp2)
    );

    cbus_sram_responder #(.MEM_WORDS(N), .LATENCY(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq0),
        .cresp  (cresp0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic randomize_fields();
        req_drv.is_write = 1'($urandom);
        req_drv.size     = 3'($urandom);
        req_drv.addr     = $urandom;
        req_drv.strobe   = 4'($urandom);
        req_drv.data     = $urandom;
        req_drv.len      = 4'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_drv.valid = 1'b0;
            randomize_fields();
            #1;
            checkOutput("idle_ready", 32'(resp_sel.ready), 32'd0);
            @(negedge clk);
        end
    endtask

    // One burst from capture to last beat; may abort by dropping valid or by reset
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                                 input int drop_after, input int reset_after);
        int          lat;
        int          d;
        int          k;
        int          idx;
        logic [31:0] exp_data;
        lat = sel ? 0 : 2;
        d   = sel ? 1 : 0;
        for (int c = 0; c <= lat + 1 + int'(len); c++) begin
            k = c - (lat + 1);
            if (drop_after >= 0 && k == drop_after) begin
                req_drv.valid = 1'b0;
                #1;
                checkOutput("drop_ready", 32'(resp_sel.ready), 32'd0);
                @(negedge clk);
                idle_cycles(2);
                return;
            end
            if (reset_after >= 0 && k == reset_after) begin
                resetn = 1'b0;
                #1;
                checkOutput("rst_ready", 32'(resp_sel.ready), 32'd0);
                checkOutput("rst_last", 32'(resp_sel.last), 32'd0);
                checkOutput("rst_data", resp_sel.data, 32'd0);
                @(negedge clk);
                req_drv.valid = 1'b0;
                resetn = 1'b1;
                return;
            end
            req_drv.valid = 1'b1;
            randomize_fields();
            if (c == 0) begin
                req_drv.is_write = wr;
                req_drv.addr     = addr;
                req_drv.len      = len;
            end
            if (k >= 0) begin
                req_drv.data   = wdata[k];
                req_drv.strobe = wstrb[k];
            end
            #1;
            idx      = (k >= 0) ? (int'(addr >> 2) + k) % N : 0;
            exp_data = 32'd0;
            if (k >= 0 && !wr) exp_data = mem_model[d][idx];
            checkOutput("ready", 32'(resp_sel.ready), 32'(k >= 0));
            checkOutput("last", 32'(resp_sel.last), 32'(k == int'(len)));
            if (k >= 0 && !wr) rd_obs[k] = resp_sel.data;
            if (!(k >= 0 && !wr && !known[d][idx])) begin
                checkOutput("data", resp_sel.data, exp_data);
            end
            @(posedge clk);
            if (k >= 0 && wr) begin
                mem_model[d][idx] = merge(mem_model[d][idx], wdata[k], wstrb[k]);
                known[d][idx]     = known[d][idx] || (wstrb[k] == 4'hF);
            end
            @(negedge clk);
        end
    endtask

    task automatic random_traffic(input int count);
        logic [31:0] a;
        for (int t = 0; t < count; t++) begin
            a = 32'(((4080 + $urandom_range(0, 31)) % N) << 2) | 32'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                wdata[i] = $urandom;
                wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            end
            applyStimulus(1'($urandom), a, len_tab[$urandom_range(0, 4)], -1, -1);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] exp;
        len_tab[0] = MLEN1;
        len_tab[1] = MLEN2;
        len_tab[2] = MLEN4;
        len_tab[3] = MLEN8;
        len_tab[4] = MLEN16;
        for (int i = 0; i < N; i++) begin
            known[0][i] = 1'b0;
            known[1][i] = 1'b0;
            mem_model[0][i] = 32'd0;
            mem_model[1][i] = 32'd0;
        end
        sel     = 1'b0;
        req_drv = '0;
        resetn  = 1'b0;
        #1;
        checkOutput("reset_resp2", {30'd0, cresp2.ready, cresp2.last}, 32'd0);
        checkOutput("reset_data2", cresp2.data, 32'd0);
        checkOutput("reset_resp0", {30'd0, cresp0.ready, cresp0.last}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle_cycles(1);

        // Four-beat write then read-back at 0x100
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 32'd11 * 32'(i + 1);
            wstrb[i] = 4'hF;
        end
        applyStimulus(1'b1, 32'h100, MLEN4, -1, -1);
        idle_cycles(1);
        applyStimulus(1'b0, 32'h100, MLEN4, -1, -1);
        for (int i = 0; i < 4; i++) begin
            exp = 32'd11 * 32'(i + 1);
            checkOutput("rt4_data", rd_obs[i], exp);
        end
        idle_cycles(1);

        // Partial-strobe single write over a known word
        wdata[0] = 32'h11223344;
        wstrb[0] = 4'hF;
        applyStimulus(1'b1, 32'h204, MLEN1, -1, -1);
        wdata[0] = 32'hAABBCCDD;
        wstrb[0] = 4'b0101;
        applyStimulus(1'b1, 32'h204, MLEN1, -1, -1);
        idle_cycles(1);
        applyStimulus(1'b0, 32'h204, MLEN1, -1, -1);
        checkOutput("strobe_merge", rd_obs[0], 32'h11BB33DD);
        idle_cycles(1);

        // Burst that wraps past the top word
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 32'h28000000 + 32'(i);
            wstrb[i] = 4'hF;
        end
        applyStimulus(1'b1, 32'h3FF8, MLEN4, -1, -1);
        idle_cycles(2);
        applyStimulus(1'b0, 32'h3FF8, MLEN4, -1, -1);
        for (int i = 0; i < 4; i++) begin
            exp = 32'h28000000 + 32'(i);
            checkOutput("wrap_data", rd_obs[i], exp);
        end
        applyStimulus(1'b0, 32'h0, MLEN2, -1, -1);
        checkOutput("wrap_word0", rd_obs[0], 32'h28000002);
        checkOutput("wrap_word1", rd_obs[1], 32'h28000003);
        idle_cycles(1);

        // Reset in the middle of an eight-beat write
        for (int i = 0; i < 8; i++) begin
            wdata[i] = 32'hA0000000 + 32'(i);
            wstrb[i] = 4'hF;
        end
        applyStimulus(1'b1, 32'h400, MLEN8, -1, -1);
        idle_cycles(1);
        for (int i = 0; i < 8; i++) wdata[i] = 32'hB0000000 + 32'(i);
        applyStimulus(1'b1, 32'h400, MLEN8, -1, 2);
        idle_cycles(1);
        applyStimulus(1'b0, 32'h400, MLEN8, -1, -1);
        for (int i = 0; i < 8; i++) begin
            exp = (i < 2) ? 32'hB0000000 + 32'(i) : 32'hA0000000 + 32'(i);
            checkOutput("rst_keep", rd_obs[i], exp);
        end
        idle_cycles(1);

        // Valid withdrawn after the first read beat, then a clean request
        applyStimulus(1'b0, 32'h100, MLEN4, 1, -1);
        applyStimulus(1'b0, 32'h104, MLEN1, -1, -1);
        checkOutput("after_drop", rd_obs[0], 32'd22);
        idle_cycles(1);

        random_traffic(25);
        idle_cycles(2);

        // Zero-latency instance: full sixteen-beat burst, then back-to-back reads
        sel = 1'b1;
        idle_cycles(1);
        for (int i = 0; i < 16; i++) begin
            wdata[i] = $urandom;
            wstrb[i] = 4'hF;
        end
        applyStimulus(1'b1, 32'h0, MLEN16, -1, -1);
        applyStimulus(1'b0, 32'h0, MLEN16, -1, -1);
        applyStimulus(1'b0, 32'h20, MLEN4, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("b2b_data", rd_obs[i], wdata[i + 8]);
        end
        idle_cycles(1);
        random_traffic(25);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
